rca_cfg_sequencer: RTL and testbench
====================================

Name: rca_cfg_sequencer

Overview:
- Accepts RCA configuration instructions (funct3 001–101) from the decode/issue stage and sequences them into single-cycle writes to the RCA configuration storage.
- Tracks outstanding RCA-use operations per RCA. A configuration write is held until every RCA it affects has drained.
- While a write is pending, new uses of the affected RCA(s) are blocked, so no in-flight RCA op ever sees a half-changed configuration.

Parameters:
- NUM_RCAS, 4, number of RCAs (RCA id = funct7, low clog2 bits)
- NUM_READ_PORTS, 5, source ports per RCA
- NUM_WRITE_PORTS, 5, destination ports per RCA
- NUM_GRID_MUXES, 72, grid MUX select count (12 rows x 6 cols)
- GRID_MUX_INPUTS, 8, legal grid sel values 0..7
- NUM_IO_UNITS, 14, IO unit count
- IO_UNIT_MUX_INPUTS, 12, legal IO MUX sel values 0..11
- MAX_OUTSTANDING, 7, per-RCA in-flight use limit (counter width 3)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config instruction offered
- cfg_ready  out  1  sequencer can accept
- cfg_funct3  in  3  instruction type
- cfg_funct7  in  7  target RCA id
- cfg_rs1  in  32  rs1 operand value
- cfg_rs2  in  32  rs2 operand value
- use_issue  in  1  RCA-use instruction issued this cycle
- use_issue_rca  in  2  RCA id of issued use
- use_done  in  1  RCA-use op completed this cycle
- use_done_rca  in  2  RCA id of completed use
- use_block  out  NUM_RCAS  per-RCA issue inhibit
- cfg_we  out  1  config write strobe (1 cycle)
- cfg_type  out  3  funct3 of the write
- cfg_rca  out  2  target RCA (0 for global grid/IO MUX writes)
- cfg_addr  out  8  select/port index
- cfg_data  out  16  value to write
- cfg_err  out  1  1-cycle pulse: illegal config instruction dropped

Behaviour:
- Reset (async, any state): FSM goes to IDLE and all counters go to 0. Output reset values: cfg_ready=1, cfg_we=0, cfg_err=0, use_block=0. cfg_type, cfg_rca, cfg_addr and cfg_data all reset to 0.
- FSM states: IDLE, DRAIN, WRITE.
- IDLE
  - cfg_ready=1.
  - On cfg_valid, latch the decoded fields.
  - If the instruction is illegal: pulse cfg_err the next cycle and stay in IDLE.
  - Otherwise go to DRAIN.
- DRAIN
  - cfg_ready=0. use_block is set for the affected RCA(s).
  - Per-RCA types (001, 100, 101) affect RCA cfg_funct7. Global types (010, 011) affect all RCAs.
  - When the outstanding count of every affected RCA is 0 (evaluated on registered counts), go to WRITE.
  - When the RCAs are already drained at accept, exactly one DRAIN cycle is spent.
- WRITE
  - cfg_we=1 for exactly one cycle, with the outputs stable.
  - Next state is IDLE, and use_block clears in that cycle.
- Latency: accept at cycle N with no outstanding uses gives cfg_we at N+2 and cfg_ready again at N+3.
- Decode and legality (a violation gives cfg_err):
  - 001 CPU reg: addr=rs1[4:0].
    - rs1[3]=0 (src): rs1[2:0] must be < NUM_READ_PORTS.
    - rs1[3]=1 (dst): rs1[2:0] must be < NUM_WRITE_PORTS.
    - data=rs2[4:0].
  - 010 grid MUX: rs1 < NUM_GRID_MUXES, rs2 < GRID_MUX_INPUTS. cfg_rca=0.
  - 011 IO MUX: rs1 < NUM_IO_UNITS, rs2 < IO_UNIT_MUX_INPUTS. cfg_rca=0.
  - 100 result MUX: rs1[2:0] < NUM_WRITE_PORTS. addr={rs1[3],rs1[2:0]}. rs2 <= NUM_IO_UNITS (value 14 = unused port, legal).
  - 101 IO use: addr=0, data=rs1[NUM_IO_UNITS-1:0]. rs1 bits above NUM_IO_UNITS-1 must be 0.
  - 000, 110, 111: illegal here.
  - Per-RCA types with funct7 >= NUM_RCAS: illegal.
- Outstanding counters, one per RCA:
  - use_issue increments; use_done decrements.
  - Issue and done on the same RCA in the same cycle: count unchanged.
  - Done at count 0: ignored, count stays 0.
  - Issue at MAX_OUTSTANDING: ignored (saturate).
- use_block[i] = affected-by-pending-config[i] OR (count[i]==MAX_OUTSTANDING).
  - Issuing while blocked is a protocol violation and is asserted in simulation.
- cfg_err and cfg_we are never high in the same cycle.
- No new cfg_valid is accepted until the FSM is back in IDLE.

Test Plan:
- Reset, then grid MUX cfg (funct3=010, rs1=5, rs2=3) with no uses outstanding → cfg_we at accept+2, cfg_addr=5, cfg_data=3, cfg_rca=0. use_block=4'b1111 for one cycle.
- Two uses issued on RCA2, then CPU reg cfg (001, funct7=2, rs1=0x09, rs2=17) → use_block[2]=1 and no cfg_we until both use_done. cfg_we follows 1 cycle after the last done, with addr=9, data=17.
- Illegal cases: grid rs1=72; IO MUX rs2=12; funct7=4 on a per-RCA type; funct3=110 → each gives a cfg_err pulse, no cfg_we, cfg_ready back to 1 after 1 cycle.
- Result MUX cfg with rs2=14 → accepted and written with data=14. Same cfg with rs2=15 → cfg_err.
- Issue and done on RCA1 in the same cycle at count 1 → count stays 1. Eight issues to RCA0 → count saturates at 7 and use_block[0]=1.
- Assert rst while in DRAIN with a pending write → immediately cfg_we=0, use_block=0, cfg_ready=1. The dropped write never appears.

Source files
------------

// File: rtl/rca_cfg_sequencer_if.sv
// Bundle between decode/issue and the RCA configuration sequencer. It carries the
// config instruction handshake, the RCA-use tracking strobes and the config-write bus.
interface rca_cfg_sequencer_if #(
  parameter int NUM_RCAS = 4
);
  localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [2:0]          cfg_funct3;
  logic [6:0]          cfg_funct7;
  logic [31:0]         cfg_rs1;
  logic [31:0]         cfg_rs2;

  logic                use_issue;
  logic [RCA_W-1:0]    use_issue_rca;
  logic                use_done;
  logic [RCA_W-1:0]    use_done_rca;
  logic [NUM_RCAS-1:0] use_block;

  logic                cfg_we;
  logic [2:0]          cfg_type;
  logic [RCA_W-1:0]    cfg_rca;
  logic [7:0]          cfg_addr;
  logic [15:0]         cfg_data;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_funct3, cfg_funct7, cfg_rs1, cfg_rs2,
    output use_issue, use_issue_rca, use_done, use_done_rca,
    input  cfg_ready, use_block, cfg_we, cfg_type, cfg_rca, cfg_addr, cfg_data, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_funct3, cfg_funct7, cfg_rs1, cfg_rs2,
    input  use_issue, use_issue_rca, use_done, use_done_rca,
    output cfg_ready, use_block, cfg_we, cfg_type, cfg_rca, cfg_addr, cfg_data, cfg_err
  );
endinterface

// File: rtl/rca_cfg_sequencer.sv
// Turns RCA configuration instructions into single-cycle config-storage writes.
// A write waits until every RCA it touches has no RCA-use op in flight.
module rca_cfg_sequencer #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 5,
  parameter int NUM_WRITE_PORTS    = 5,
  parameter int NUM_GRID_MUXES     = 72,
  parameter int GRID_MUX_INPUTS    = 8,
  parameter int NUM_IO_UNITS       = 14,
  parameter int IO_UNIT_MUX_INPUTS = 12,
  parameter int MAX_OUTSTANDING    = 7
) (
  input logic                clk,
  input logic                rst,
  rca_cfg_sequencer_if.slave bus
);
  localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [2:0] F_CPU_REG = 3'b001;
  localparam logic [2:0] F_GRID    = 3'b010;
  localparam logic [2:0] F_IO_MUX  = 3'b011;
  localparam logic [2:0] F_RES_MUX = 3'b100;
  localparam logic [2:0] F_IO_USE  = 3'b101;

  logic [1:0]          state;
  logic [NUM_RCAS-1:0] aff_mask;
  logic                err_q;
  logic [2:0]          type_q;
  logic [RCA_W-1:0]    rca_q;
  logic [7:0]          addr_q;
  logic [15:0]         data_q;
  logic [CNT_W-1:0]    cnt [NUM_RCAS];

  logic                dec_legal;
  logic                dec_global;
  logic [7:0]          dec_addr;
  logic [15:0]         dec_data;
  logic [NUM_RCAS-1:0] dec_mask;
  logic                rca_ok;
  logic [RCA_W-1:0]    rca_id;
  logic [NUM_RCAS-1:0] inc, dec, busy, sat, cfg_block;

  assign rca_id = bus.cfg_funct7[RCA_W-1:0];
  assign rca_ok = bus.cfg_funct7 < 7'(NUM_RCAS);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dec_legal  = 1'b0;
    dec_global = 1'b0;
    dec_addr   = '0;
    dec_data   = '0;
    case (bus.cfg_funct3)
      F_CPU_REG: begin
        // rs1[3] picks a destination port (1) or a source port (0)
        dec_legal = rca_ok && (bus.cfg_rs1[3] ? (32'(bus.cfg_rs1[2:0]) < 32'(NUM_WRITE_PORTS))
                                              : (32'(bus.cfg_rs1[2:0]) < 32'(NUM_READ_PORTS)));
        dec_addr  = 8'(bus.cfg_rs1[4:0]);
        dec_data  = 16'(bus.cfg_rs2[4:0]);
      end
      F_GRID: begin
        dec_global = 1'b1;
        dec_legal  = (bus.cfg_rs1 < 32'(NUM_GRID_MUXES)) && (bus.cfg_rs2 < 32'(GRID_MUX_INPUTS));
        dec_addr   = bus.cfg_rs1[7:0];
        dec_data   = bus.cfg_rs2[15:0];
      end
      F_IO_MUX: begin
        dec_global = 1'b1;
        dec_legal  = (bus.cfg_rs1 < 32'(NUM_IO_UNITS)) && (bus.cfg_rs2 < 32'(IO_UNIT_MUX_INPUTS));
        dec_addr   = bus.cfg_rs1[7:0];
        dec_data   = bus.cfg_rs2[15:0];
      end
      F_RES_MUX: begin
        // rs2 == NUM_IO_UNITS marks the write port as unused
        dec_legal = rca_ok && (32'(bus.cfg_rs1[2:0]) < 32'(NUM_WRITE_PORTS))
                           && (bus.cfg_rs2 <= 32'(NUM_IO_UNITS));
        dec_addr  = 8'({bus.cfg_rs1[3], bus.cfg_rs1[2:0]});
        dec_data  = bus.cfg_rs2[15:0];
      end
      F_IO_USE: begin
        dec_legal = rca_ok && ((bus.cfg_rs1 >> NUM_IO_UNITS) == 32'd0);
        dec_data  = 16'(bus.cfg_rs1[NUM_IO_UNITS-1:0]);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_mask = dec_global ? {NUM_RCAS{1'b1}} : ({{(NUM_RCAS-1){1'b0}}, 1'b1} << rca_id);

  always_comb begin
    for (int i = 0; i < NUM_RCAS; i++) begin
      inc[i]  = bus.use_issue && (bus.use_issue_rca == RCA_W'(i));
      dec[i]  = bus.use_done  && (bus.use_done_rca  == RCA_W'(i));
      busy[i] = cnt[i] != '0;
      sat[i]  = cnt[i] == CNT_MAX;
    end
  end

  // NOTE: the counters are a handful of flops, not a RAM, so they are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RCAS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (inc[i] && !dec[i]) begin
          if (!sat[i]) cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          if (busy[i]) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      aff_mask <= '0;
      err_q    <= 1'b0;
      type_q   <= '0;
      rca_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            type_q   <= bus.cfg_funct3;
            rca_q    <= dec_global ? '0 : rca_id;
            addr_q   <= dec_addr;
            data_q   <= dec_data;
            aff_mask <= dec_mask;
            if (dec_legal) state <= DRAIN;
            else           err_q <= 1'b1;
          end
        end
        DRAIN:   if ((aff_mask & busy) == '0) state <= WRITE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Uses are held off only while the write is still waiting to drain.
  assign cfg_block     = (state == DRAIN) ? aff_mask : '0;
  assign bus.use_block = cfg_block | sat;
  assign bus.cfg_ready = state == IDLE;
  assign bus.cfg_we    = state == WRITE;
  assign bus.cfg_err   = err_q;
  assign bus.cfg_type  = type_q;
  assign bus.cfg_rca   = rca_q;
  assign bus.cfg_addr  = addr_q;
  assign bus.cfg_data  = data_q;

  always @(posedge clk) begin
    if (!rst && bus.use_issue) begin
      issue_while_blocked: assert (!cfg_block[bus.use_issue_rca]);
    end
  end
endmodule

// File: tb/tb_rca_cfg_sequencer.sv
// Bench for rca_cfg_sequencer: directed scenarios plus randomized config/use traffic,
// all judged against a behavioural model of decode rules and per-RCA use counts.
module tb_rca_cfg_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_cfg_sequencer_if #(.NUM_RCAS(4)) bus ();
  rca_cfg_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        ok;
    logic [1:0]  rca;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  mask;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int mcnt [4];

  function automatic exp_t ref_decode(input int unsigned f3, f7, rs1, rs2);
    exp_t e;
    bit rca_ok;
    bit global_t;
    e = '0;
    rca_ok   = f7 < 4;
    global_t = (f3 == 2) || (f3 == 3);
    case (f3)
      1: begin
        e.ok   = rca_ok && ((((rs1 / 8) % 2) == 1) ? (rs1 % 8) < 5 : (rs1 % 8) < 5);
        e.addr = 8'(rs1 % 32);
        e.data = 16'(rs2 % 32);
      end
      2: begin e.ok = rs1 < 72 && rs2 < 8;  e.addr = 8'(rs1); e.data = 16'(rs2); end
      3: begin e.ok = rs1 < 14 && rs2 < 12; e.addr = 8'(rs1); e.data = 16'(rs2); end
      4: begin
        e.ok   = rca_ok && (rs1 % 8) < 5 && rs2 <= 14;
        e.addr = 8'(rs1 % 16);
        e.data = 16'(rs2);
      end
      5: begin e.ok = rca_ok && rs1 < (1 << 14); e.addr = 8'd0; e.data = 16'(rs1); end
      default: e.ok = 1'b0;
    endcase
    e.rca  = global_t ? 2'd0 : 2'(f7 % 4);
    e.mask = global_t ? 4'hf : 4'(1 << (f7 % 4));
    return e;
  endfunction

  function automatic logic [3:0] sat_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (mcnt[i] == 7);
    return m;
  endfunction

  function automatic bit drained(input logic [3:0] mask);
    bit d = 1'b1;
    for (int i = 0; i < 4; i++) if (mask[i] && mcnt[i] != 0) d = 1'b0;
    return d;
  endfunction

  // One clock: the model absorbs the strobes presented at the edge, pulses are dropped,
  // and control returns at the following falling edge where outputs are sampled.
  task automatic adv();
    @(posedge clk);
    if (!rst) begin
      if (!(bus.use_issue && bus.use_done && bus.use_issue_rca == bus.use_done_rca)) begin
        if (bus.use_issue && mcnt[bus.use_issue_rca] < 7) mcnt[bus.use_issue_rca]++;
        if (bus.use_done && mcnt[bus.use_done_rca] > 0)   mcnt[bus.use_done_rca]--;
      end
    end
    #1;
    bus.cfg_valid = 1'b0;
    bus.use_issue = 1'b0;
    bus.use_done  = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue(input int r);
    bus.use_issue     = 1'b1;
    bus.use_issue_rca = 2'(r);
    adv();
  endtask

  task automatic done(input int r);
    bus.use_done     = 1'b1;
    bus.use_done_rca = 2'(r);
    adv();
  endtask

  // Present one config instruction and follow it to cfg_err or to its write.
  task automatic run_cfg(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input string tag);
    exp_t e;
    int   n;
    int   r;
    e = ref_decode(f3, f7, rs1, rs2);
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_at_offer got=%b want=1", tag, bus.cfg_ready);
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_funct3 = f3;
    bus.cfg_funct7 = f7;
    bus.cfg_rs1    = rs1;
    bus.cfg_rs2    = rs2;
    adv();
    if (!e.ok) begin
      total++;
      if (bus.cfg_err !== 1'b1 || bus.cfg_we !== 1'b0) begin
        bad++; $display("FAIL %s err_pulse got err=%b we=%b want err=1 we=0", tag, bus.cfg_err, bus.cfg_we);
      end
      adv();
      total++;
      if (bus.cfg_err !== 1'b0 || bus.cfg_we !== 1'b0 || bus.cfg_ready !== 1'b1) begin
        bad++; $display("FAIL %s after_err got err=%b we=%b ready=%b want 0/0/1",
                        tag, bus.cfg_err, bus.cfg_we, bus.cfg_ready);
      end
      return;
    end
    n = 0;
    while (1) begin
      total++;
      if (bus.cfg_we !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.cfg_err !== 1'b0 ||
          bus.use_block !== (e.mask | sat_mask())) begin
        bad++; $display("FAIL %s drain got we=%b ready=%b err=%b block=%b want 0/0/0 block=%b",
                        tag, bus.cfg_we, bus.cfg_ready, bus.cfg_err, bus.use_block, e.mask | sat_mask());
      end
      if (drained(e.mask)) break;
      if (++n > 300) begin
        bad++; total++; $display("FAIL %s drain_timeout got no write want write", tag);
        return;
      end
      r = -1;
      for (int i = 0; i < 4; i++) if (r < 0 && e.mask[i] && mcnt[i] > 0) r = i;
      if (r >= 0 && $urandom_range(0, 1) == 1) begin
        bus.use_done = 1'b1; bus.use_done_rca = 2'(r);
      end
      r = $urandom_range(0, 3);
      if (!e.mask[r] && mcnt[r] < 7 && $urandom_range(0, 3) == 0) begin
        bus.use_issue = 1'b1; bus.use_issue_rca = 2'(r);
      end
      adv();
    end
    adv();
    total++;
    if (bus.cfg_we !== 1'b1 || bus.cfg_err !== 1'b0 || bus.cfg_type !== f3 || bus.cfg_rca !== e.rca ||
        bus.cfg_addr !== e.addr || bus.cfg_data !== e.data || bus.use_block !== sat_mask()) begin
      bad++; $display("FAIL %s write got we=%b err=%b type=%0d rca=%0d addr=%0d data=%0d block=%b want 1/0/%0d/%0d/%0d/%0d/%b",
                      tag, bus.cfg_we, bus.cfg_err, bus.cfg_type, bus.cfg_rca, bus.cfg_addr, bus.cfg_data,
                      bus.use_block, f3, e.rca, e.addr, e.data, sat_mask());
    end
    adv();
    total++;
    if (bus.cfg_we !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL %s post_write got we=%b ready=%b want 0/1", tag, bus.cfg_we, bus.cfg_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.cfg_ready !== 1'b1 || bus.cfg_we !== 1'b0 || bus.cfg_err !== 1'b0 || bus.use_block !== 4'b0 ||
        bus.cfg_type !== 3'd0 || bus.cfg_rca !== 2'd0 || bus.cfg_addr !== 8'd0 || bus.cfg_data !== 16'd0) begin
      bad++; $display("FAIL reset_values got ready=%b we=%b err=%b block=%b type=%0d rca=%0d addr=%0d data=%0d want 1/0/0/0000/0/0/0/0",
                      bus.cfg_ready, bus.cfg_we, bus.cfg_err, bus.use_block, bus.cfg_type, bus.cfg_rca,
                      bus.cfg_addr, bus.cfg_data);
    end
    rst = 1'b0;
    adv();
    total++;
    if (bus.cfg_ready !== 1'b1 || bus.cfg_we !== 1'b0 || bus.use_block !== 4'b0) begin
      bad++; $display("FAIL idle_after_reset got ready=%b we=%b block=%b want 1/0/0000",
                      bus.cfg_ready, bus.cfg_we, bus.use_block);
    end
  endtask

  task automatic test_grid();
    run_cfg(3'b010, 7'd0, 32'd5, 32'd3, "grid_basic");
  endtask

  task automatic test_drain();
    issue(2);
    issue(2);
    run_cfg(3'b001, 7'd2, 32'h09, 32'd17, "cpu_reg_drain");
  endtask

  task automatic test_illegal();
    run_cfg(3'b010, 7'd0, 32'd72, 32'd0, "grid_rs1_72");
    run_cfg(3'b011, 7'd0, 32'd0,  32'd12, "io_mux_rs2_12");
    run_cfg(3'b001, 7'd4, 32'd0,  32'd0, "funct7_4");
    run_cfg(3'b110, 7'd0, 32'd0,  32'd0, "funct3_110");
    run_cfg(3'b011, 7'd0, 32'd13, 32'd11, "io_mux_max");
  endtask

  task automatic test_result_mux();
    run_cfg(3'b100, 7'd1, 32'h0c, 32'd14, "res_mux_14");
    run_cfg(3'b100, 7'd1, 32'h0c, 32'd15, "res_mux_15");
  endtask

  task automatic test_same_cycle();
    while (mcnt[1] > 1) done(1);
    if (mcnt[1] == 0) issue(1);
    bus.use_issue = 1'b1; bus.use_issue_rca = 2'd1;
    bus.use_done  = 1'b1; bus.use_done_rca  = 2'd1;
    adv();
    run_cfg(3'b001, 7'd1, 32'h03, 32'd4, "same_cycle_rca1");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) begin
      issue(0);
      if (i >= 6) begin
        total++;
        if (bus.use_block[0] !== 1'b1) begin
          bad++; $display("FAIL saturate_block issue=%0d got=%b want=1", i + 1, bus.use_block[0]);
        end
      end
    end
    run_cfg(3'b101, 7'd0, 32'h2abc, 32'd0, "io_use_sat");
    run_cfg(3'b101, 7'd0, 32'h4000, 32'd0, "io_use_wide");
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] rs1, rs2;
    int k;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        int r = $urandom_range(0, 3);
        if (mcnt[r] < 7) issue(r);
      end
      f3  = 3'($urandom_range(0, 7));
      f7  = 7'($urandom_range(0, 5));
      rs1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 80));
      rs2 = 32'($urandom_range(0, 16));
      run_cfg(f3, f7, rs1, rs2, "random");
    end
  endtask

  task automatic test_reset_in_drain();
    issue(3);
    bus.cfg_valid = 1'b1; bus.cfg_funct3 = 3'b001; bus.cfg_funct7 = 7'd3;
    bus.cfg_rs1 = 32'd1; bus.cfg_rs2 = 32'd2;
    adv();
    total++;
    if (bus.cfg_ready !== 1'b0 || bus.use_block[3] !== 1'b1) begin
      bad++; $display("FAIL rst_drain_setup got ready=%b block3=%b want 0/1", bus.cfg_ready, bus.use_block[3]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.cfg_we !== 1'b0 || bus.use_block !== 4'b0 || bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0) begin
      bad++; $display("FAIL rst_async got we=%b block=%b ready=%b err=%b want 0/0000/1/0",
                      bus.cfg_we, bus.use_block, bus.cfg_ready, bus.cfg_err);
    end
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      adv();
      total++;
      if (bus.cfg_we !== 1'b0 || bus.cfg_ready !== 1'b1) begin
        bad++; $display("FAIL rst_dropped_write cycle=%0d got we=%b ready=%b want 0/1", c, bus.cfg_we, bus.cfg_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_funct3 = '0; bus.cfg_funct7 = '0;
    bus.cfg_rs1 = '0; bus.cfg_rs2 = '0;
    bus.use_issue = 1'b0; bus.use_issue_rca = '0;
    bus.use_done  = 1'b0; bus.use_done_rca  = '0;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_grid();
    test_drain();
    test_illegal();
    test_result_mux();
    test_same_cycle();
    test_saturation();
    test_random();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
